// File: rtl/lcd_bl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bl_pkg
// Brief    : Shared defaults and state encoding for the LCD backlight ramp.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_bl_pkg;

  localparam int DEF_PERIOD    = 4000;
  localparam int DEF_RAMP_STEP = 16;
  localparam int DEF_DUTY_W    = 12;

  typedef logic [1:0] bl_state_t;

  localparam bl_state_t ST_OFF       = 2'd0;
  localparam bl_state_t ST_RAMP_UP   = 2'd1;
  localparam bl_state_t ST_ON        = 2'd2;
  localparam bl_state_t ST_RAMP_DOWN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lcd_bl_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bl_pwm_gen
// Brief    : Free-running period counter with registered duty comparator.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bl_pwm_gen
  import lcd_bl_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int DUTY_W = DEF_DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  output logic              tick,
  output logic              pwm
);

  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] ONE  = DUTY_W'(1);

  logic [DUTY_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + ONE;
      pwm <= (cnt < duty);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bl_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bl_ramp_ctrl
// Brief    : Backlight PWM with per-period duty ramping; LCD_BL_SOFT_RAMP_EN
//            enables gradual ramping, otherwise duty jumps to target at tick.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bl_ramp_ctrl
  import lcd_bl_pkg::*;
#(
  parameter int PERIOD    = DEF_PERIOD,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int DUTY_W    = DEF_DUTY_W
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_bl_on,
  input  logic [DUTY_W-1:0] I_target_duty,
  output logic              O_lcd_pwm,
  output logic [1:0]        O_bl_state,
  output logic [DUTY_W-1:0] O_cur_duty,
  output logic              O_ramp_done
);

`ifdef LCD_BL_SOFT_RAMP_EN
  localparam int STEP_LIM = RAMP_STEP;
`else
  // A step spanning the whole duty range turns every tick into a direct jump.
  localparam int STEP_LIM = (RAMP_STEP > PERIOD) ? RAMP_STEP : PERIOD;
`endif

  localparam logic [DUTY_W-1:0] PER  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'((STEP_LIM > PERIOD) ? PERIOD : STEP_LIM);

  logic              tick;
  logic [DUTY_W-1:0] cur_duty;
  logic [DUTY_W-1:0] nxt_duty;
  logic [DUTY_W-1:0] tgt_clamp;
  logic [DUTY_W-1:0] target_eff;
  logic [DUTY_W-1:0] diff;
  bl_state_t         state;
  bl_state_t         nxt_state;
  logic              done_r;
  logic              nxt_done;

  lcd_bl_pwm_gen #(
    .PERIOD (PERIOD),
    .DUTY_W (DUTY_W)
  ) u_pwm_gen (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .duty  (cur_duty),
    .tick  (tick),
    .pwm   (O_lcd_pwm)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state    <= ST_OFF;
      cur_duty <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= nxt_state;
      cur_duty <= nxt_duty;
      done_r   <= nxt_done;
    end
  end

  // Differences are taken only in the direction that is known non-negative,
  // and cur + step never exceeds target_eff <= PERIOD.
  always_comb begin
    tgt_clamp  = (I_target_duty > PER) ? PER : I_target_duty;
    target_eff = I_bl_on ? tgt_clamp : '0;
    diff       = '0;
    nxt_duty   = cur_duty;
    nxt_state  = state;
    nxt_done   = 1'b0;
    if (tick) begin
      if (cur_duty < target_eff) begin
        diff     = target_eff - cur_duty;
        nxt_duty = cur_duty + ((diff > STEP) ? STEP : diff);
      end else if (cur_duty > target_eff) begin
        diff     = cur_duty - target_eff;
        nxt_duty = cur_duty - ((diff > STEP) ? STEP : diff);
      end

      if (nxt_duty < target_eff) begin
        nxt_state = ST_RAMP_UP;
      end else if (nxt_duty > target_eff) begin
        nxt_state = ST_RAMP_DOWN;
      end else if (I_bl_on) begin
        nxt_state = ST_ON;
      end else begin
        nxt_state = ST_OFF;
      end

      nxt_done = (nxt_duty != cur_duty) && (nxt_duty == target_eff);
    end
  end

  always_comb begin
    O_bl_state  = state;
    O_cur_duty  = cur_duty;
    O_ramp_done = done_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bl_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bl_ramp_ctrl
// Brief    : Directed self-checking bench for lcd_bl_ramp_ctrl (scaled period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bl_ramp_ctrl;

  localparam int PERIOD    = 50;
  localparam int RAMP_STEP = 4;
  localparam int DUTY_W    = 8;

`ifdef LCD_BL_SOFT_RAMP_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              bl_on;
  logic [DUTY_W-1:0] target_duty;
  logic              lcd_pwm;
  logic [1:0]        bl_state;
  logic [DUTY_W-1:0] cur_duty;
  logic              ramp_done;

  int n_checks;
  int n_fail;
  int done_total;
  int pwm_hi;
  int d0;

  lcd_bl_ramp_ctrl #(
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP),
    .DUTY_W    (DUTY_W)
  ) dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_bl_on       (bl_on),
    .I_target_duty (target_duty),
    .O_lcd_pwm     (lcd_pwm),
    .O_bl_state    (bl_state),
    .O_cur_duty    (cur_duty),
    .O_ramp_done   (ramp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle, sampling on the falling edge.
  task automatic step();
    @(negedge clk);
    if (lcd_pwm === 1'b1) pwm_hi++;
    if (ramp_done === 1'b1) done_total++;
  endtask

  task automatic run_ticks(input int n);
    repeat (n * PERIOD) step();
  endtask

  // Count PWM high cycles over exactly one period.
  task automatic measure_pwm(input string tag, input int exp);
    pwm_hi = 0;
    repeat (PERIOD) step();
    check_val(tag, pwm_hi, exp);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    done_total  = 0;
    pwm_hi      = 0;
    rst_n       = 1'b1;
    bl_on       = 1'b0;
    target_duty = '0;

    #1 rst_n = 1'b0;
    #2;
    check_val("rst_state", bl_state, 0);
    check_val("rst_cur", cur_duty, 0);
    check_val("rst_pwm", lcd_pwm, 0);
    check_val("rst_done", ramp_done, 0);
    repeat (2) @(negedge clk);

    // Ramp up to 30
    bl_on       = 1'b1;
    target_duty = 8'd30;
    rst_n       = 1'b1;
    d0 = done_total;
    run_ticks(1);
    check_val("up_t1_cur", cur_duty, SOFT ? 4 : 30);
    check_val("up_t1_state", bl_state, SOFT ? 1 : 2);
    run_ticks(6);
    check_val("up_t7_cur", cur_duty, SOFT ? 28 : 30);
    check_val("up_t7_state", bl_state, SOFT ? 1 : 2);
    run_ticks(1);
    check_val("up_t8_cur", cur_duty, 30);
    check_val("up_t8_state", bl_state, 2);
    check_val("up_t8_done", ramp_done, SOFT ? 1 : 0);
    check_val("up_done_cnt", done_total - d0, 1);
    measure_pwm("up_pwm_hi", 30);

    // Ramp down to off
    bl_on = 1'b0;
    d0 = done_total;
    run_ticks(1);
    check_val("dn_t1_cur", cur_duty, SOFT ? 26 : 0);
    check_val("dn_t1_state", bl_state, SOFT ? 3 : 0);
    run_ticks(7);
    check_val("dn_t8_cur", cur_duty, 0);
    check_val("dn_t8_state", bl_state, 0);
    check_val("dn_done_cnt", done_total - d0, 1);
    measure_pwm("dn_pwm_hi", 0);

    // Target above PERIOD is clamped
    bl_on       = 1'b1;
    target_duty = 8'd200;
    d0 = done_total;
    run_ticks(13);
    check_val("clamp_cur", cur_duty, 50);
    check_val("clamp_state", bl_state, 2);
    check_val("clamp_done_cnt", done_total - d0, 1);
    measure_pwm("clamp_pwm_hi", 50);

    // Redirect mid-ramp
    bl_on = 1'b0;
    run_ticks(13);
    check_val("off_again_cur", cur_duty, 0);
    bl_on       = 1'b1;
    target_duty = 8'd30;
    d0 = done_total;
    run_ticks(3);
    check_val("redir_pre_cur", cur_duty, SOFT ? 12 : 30);
    check_val("redir_pre_state", bl_state, SOFT ? 1 : 2);
    bl_on = 1'b0;
    run_ticks(1);
    check_val("redir_cur", cur_duty, SOFT ? 8 : 0);
    check_val("redir_state", bl_state, SOFT ? 3 : 0);
    check_val("redir_done", ramp_done, SOFT ? 0 : 1);
    check_val("redir_done_cnt", done_total - d0, SOFT ? 0 : 2);
    run_ticks(2);
    check_val("redir_end_cur", cur_duty, 0);
    check_val("redir_end_state", bl_state, 0);

    // On with zero target
    bl_on       = 1'b1;
    target_duty = 8'd0;
    d0 = done_total;
    run_ticks(1);
    check_val("zero_cur", cur_duty, 0);
    check_val("zero_state", bl_state, 2);
    check_val("zero_done_cnt", done_total - d0, 0);
    measure_pwm("zero_pwm_hi", 0);

    // Asynchronous reset mid-ramp
    target_duty = 8'd30;
    run_ticks(3);
    check_val("mid_cur", cur_duty, SOFT ? 12 : 30);
    repeat (5) step();
    check_val("mid_pwm", lcd_pwm, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_state", bl_state, 0);
    check_val("arst_cur", cur_duty, 0);
    check_val("arst_pwm", lcd_pwm, 0);
    check_val("arst_done", ramp_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (PERIOD - 1) step();
    check_val("post_rst_pre_tick", cur_duty, 0);
    step();
    check_val("post_rst_tick_cur", cur_duty, SOFT ? 4 : 30);
    check_val("post_rst_tick_state", bl_state, SOFT ? 1 : 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
